// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, oversampled at OVERSAMPLE x BAUD off the system clock.
// Define UART_RX_PARITY_EN to insert an even-parity bit and the parity_err output.
module uart_rx #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int unsigned CLKS_PER_TICK = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV_W  = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLKS_PER_TICK - 1);
  localparam logic [TICK_W-1:0] MID_START = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t            state;
  logic              rx_meta;
  logic              rx_s;
  logic [DIV_W-1:0]  div_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_reg;
  logic              tick_c;
`ifdef UART_RX_PARITY_EN
  logic              par_bit;
`endif

  assign tick_c = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      div_cnt    <= '0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      rx_meta    <= rx_in;
      rx_s       <= rx_meta;
      div_cnt    <= tick_c ? '0 : div_cnt + DIV_W'(1);

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            busy     <= 1'b1;
            div_cnt  <= '0;
            tick_cnt <= '0;
          end
        end

        // Mid start bit: a high line here was only a glitch
        START: begin
          if (tick_c) begin
            if (tick_cnt == MID_START) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              if (rx_s) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end

        DATA: begin
          if (tick_c) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt  <= '0;
              shift_reg <= {rx_s, shift_reg[7:1]};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_c) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              par_bit  <= rx_s;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end
`endif

        // Leaving at mid stop bit leaves half a bit to catch a back-to-back start
        STOP: begin
          if (tick_c) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              if (rx_s) begin
                data_out   <= shift_reg;
                data_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err <= (^shift_reg) ^ par_bit;
`endif
                state      <= IDLE;
                busy       <= 1'b0;
              end else begin
                frame_err <= 1'b1;
                state     <= WAIT_IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end

        WAIT_IDLE: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          tick_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; honours UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int BIT = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LATENCY = 171;
`else
  localparam int LATENCY = 155;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  int both_cnt = 0;
  int last_dv_cyc = 0;
  logic [7:0] rx_q[$];

  uart_rx #(.CLK_FREQ(160), .BAUD(10), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt++;
      rx_q.push_back(data_out);
      last_dv_cyc = cyc;
    end
    if (frame_err) fe_cnt++;
    if (data_valid && frame_err) both_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt++;
    if (parity_err && !data_valid) both_cnt++;
`endif
  end

  task automatic send_bit(input logic v);
    rx_in = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^b);
`endif
    send_bit(stop_bit);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b expected 0", data_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_fe: got %b expected 0", frame_err); end
    n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data_out); end
  endtask

  task automatic test_single;
    int c0;
    c0 = cyc;
    send_frame(8'h54, 1'b1);
    repeat (10) @(negedge clk);
    n_cmp++; if (dv_cnt !== 1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", dv_cnt); end
    n_cmp++; if (data_out !== 8'h54) begin n_fail++; $display("FAIL single_data: got %h expected 54", data_out); end
    n_cmp++; if (last_dv_cyc - c0 < LATENCY - 1 || last_dv_cyc - c0 > LATENCY + 1) begin
      n_fail++; $display("FAIL single_latency: got %0d expected %0d", last_dv_cyc - c0, LATENCY); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", busy); end
    rx_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b[4];
    int fe0;
    exp_b = '{8'h61, 8'h72, 8'h74, 8'h7A};
    fe0 = fe_cnt;
    for (int i = 0; i < 4; i++) send_frame(exp_b[i], 1'b1);
    repeat (20) @(negedge clk);
    n_cmp++; if (rx_q.size() !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d expected 4", rx_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= rx_q.size()) begin n_fail++; $display("FAIL b2b_data%0d: got none expected %h", i, exp_b[i]); end
      else if (rx_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL b2b_data%0d: got %h expected %h", i, rx_q[i], exp_b[i]); end
    end
    n_cmp++; if (fe_cnt !== fe0) begin n_fail++; $display("FAIL b2b_fe: got %0d expected %0d", fe_cnt, fe0); end
    rx_q.delete();
  endtask

  task automatic test_glitch;
    int dv0, fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    rx_in = 1'b0;
    repeat (5) @(negedge clk);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_start_busy: got %b expected 1", busy); end
    repeat (30) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got %b expected 0", busy); end
    n_cmp++; if (dv_cnt !== dv0 || fe_cnt !== fe0) begin
      n_fail++; $display("FAIL glitch_strobe: got dv %0d fe %0d expected dv %0d fe %0d", dv_cnt, fe_cnt, dv0, fe0); end
  endtask

  task automatic test_frame_err;
    int dv0, fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h41, 1'b0);
    rx_in = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_held: got %b expected 1", busy); end
    n_cmp++; if (fe_cnt !== fe0 + 1) begin n_fail++; $display("FAIL ferr_count: got %0d expected %0d", fe_cnt, fe0 + 1); end
    n_cmp++; if (dv_cnt !== dv0) begin n_fail++; $display("FAIL ferr_no_dv: got %0d expected %0d", dv_cnt, dv0); end
    n_cmp++; if (data_out !== 8'h7A) begin n_fail++; $display("FAIL ferr_data_hold: got %h expected 7a", data_out); end
    rx_in = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_release: got %b expected 0", busy); end
    n_cmp++; if (fe_cnt !== fe0 + 1) begin n_fail++; $display("FAIL ferr_once: got %0d expected %0d", fe_cnt, fe0 + 1); end
    send_frame(8'h42, 1'b1);
    repeat (10) @(negedge clk);
    n_cmp++; if (rx_q.size() !== 1 || data_out !== 8'h42) begin
      n_fail++; $display("FAIL ferr_recover: got %0d bytes data %h expected 1 bytes data 42", rx_q.size(), data_out); end
    rx_q.delete();
  endtask

  task automatic test_reset_mid;
    int dv0, fe0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rx_in = 1'b1;
    repeat (8) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_pre: got %b expected 1", busy); end
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (data_out !== 8'h00 || busy !== 1'b0 || data_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL rmid_outputs: got data %h busy %b dv %b fe %b expected all 0", data_out, busy, data_valid, frame_err); end
    repeat (40) @(negedge clk);
    n_cmp++; if (dv_cnt !== dv0 || fe_cnt !== fe0) begin
      n_fail++; $display("FAIL rmid_no_strobe: got dv %0d fe %0d expected dv %0d fe %0d", dv_cnt, fe_cnt, dv0, fe0); end
    send_frame(8'h33, 1'b1);
    repeat (10) @(negedge clk);
    n_cmp++; if (rx_q.size() !== 1 || data_out !== 8'h33) begin
      n_fail++; $display("FAIL rmid_recover: got %0d bytes data %h expected 1 bytes data 33", rx_q.size(), data_out); end
    rx_q.delete();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] b, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(1'b1);
  endtask

  task automatic test_parity;
    int dv0, pe0;
    dv0 = dv_cnt;
    pe0 = pe_cnt;
    send_frame_par(8'h03, 1'b0);
    repeat (10) @(negedge clk);
    n_cmp++; if (dv_cnt !== dv0 + 1 || pe_cnt !== pe0) begin
      n_fail++; $display("FAIL par_good: got dv %0d pe %0d expected dv %0d pe %0d", dv_cnt, pe_cnt, dv0 + 1, pe0); end
    send_frame_par(8'h07, 1'b0);
    repeat (10) @(negedge clk);
    n_cmp++; if (dv_cnt !== dv0 + 2 || pe_cnt !== pe0 + 1) begin
      n_fail++; $display("FAIL par_bad: got dv %0d pe %0d expected dv %0d pe %0d", dv_cnt, pe_cnt, dv0 + 2, pe0 + 1); end
    n_cmp++; if (data_out !== 8'h07) begin n_fail++; $display("FAIL par_data: got %h expected 07", data_out); end
    rx_q.delete();
  endtask
`endif

  task automatic test_exclusive;
    n_cmp++; if (both_cnt !== 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d expected 0", both_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    rx_in = 1'b1;
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_reset_mid;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    test_exclusive;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
